sm_dmem_arbiter: RTL and testbench

- Shares one single-port synchronous data RAM between the CPU load/store port and a debug/loader port.
- Issues at most one RAM access per cycle.
- The CPU has fixed priority. The debug port has a bounded-wait starvation guard.
- Sits between sm_cpu's data-memory interface and the data RAM; the debug port is driven by the board-level monitor.

---
 rtl/sm_dmem_arbiter.sv | 116 +++++++++++
 tb/tb_sm_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_dmem_arbiter.sv
// Shares one single-port data RAM between the CPU and debug ports; CPU wins unless debug has waited MAX_WAIT cycles (optional counters under SM_DMEM_ARB_STATS_EN).
// Latency: grants are combinational in the address phase; the ack and read data follow exactly one cycle later.
// Backpressure: a denied requester sees no gnt (cpu_stall for the CPU) and simply holds req; there is no queueing.
module sm_dmem_arbiter #(
    parameter int AW       = 6,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wd,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rd,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wd,
    output logic          dbg_gnt,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rd,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
`ifdef SM_DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_stalls,
    output logic [15:0]   stat_dbg_grants
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CPU_DATA,
        DBG_DATA
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t     state;
    state_t     state_nxt;
    logic       rd_pending;
    logic [3:0] wait_cnt;
    logic       force_dbg;

    always_comb begin
        force_dbg = 1'b0;
        dbg_gnt   = 1'b0;
        cpu_gnt   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wd    = '0;
        state_nxt = IDLE;

        force_dbg = dbg_req & (wait_cnt == WAIT_MAX);
        dbg_gnt   = dbg_req & (force_dbg | ~cpu_req);
        cpu_gnt   = cpu_req & ~dbg_gnt;

        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wd    = cpu_wd;
            state_nxt = CPU_DATA;
        end else if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wd    = dbg_wd;
            state_nxt = DBG_DATA;
        end
    end

    // A grant sampled while rst is high is dropped: its data phase never starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_pending <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            rd_pending <= mem_en & ~mem_we;
            if (~dbg_req | dbg_gnt)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign cpu_ack   = (state == CPU_DATA);
    assign dbg_ack   = (state == DBG_DATA);
    assign cpu_rd    = (cpu_ack & rd_pending) ? mem_rd : 32'd0;
    assign dbg_rd    = (dbg_ack & rd_pending) ? mem_rd : 32'd0;

`ifdef SM_DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stalls     <= '0;
            stat_dbg_grants <= '0;
        end else begin
            if (cpu_stall && (stat_stalls != 16'hFFFF))
                stat_stalls <= stat_stalls + 16'd1;
            if (dbg_gnt && (stat_dbg_grants != 16'hFFFF))
                stat_dbg_grants <= stat_dbg_grants + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sm_dmem_arbiter.sv
// Bench for sm_dmem_arbiter: directed table, reset/starvation sequences, and random traffic against a transaction-level model.
module tb_sm_dmem_arbiter;

    localparam int AW       = 6;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [31:0]   cpu_wd, dbg_wd;
    logic          cpu_gnt, cpu_stall, cpu_ack, dbg_gnt, dbg_ack;
    logic [31:0]   cpu_rd, dbg_rd;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;
`ifdef SM_DMEM_ARB_STATS_EN
    logic [15:0]   stat_stalls, stat_dbg_grants;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sm_dmem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_ack(cpu_ack), .cpu_rd(cpu_rd),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
        .dbg_gnt(dbg_gnt), .dbg_ack(dbg_ack), .dbg_rd(dbg_rd),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
`ifdef SM_DMEM_ARB_STATS_EN
        , .stat_stalls(stat_stalls), .stat_dbg_grants(stat_dbg_grants)
`endif
    );

    // Write-first single-port RAM; cleared once at start of simulation.
    logic [31:0] ram [0:(1<<AW)-1];
    logic        ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < (1<<AW); i++) ram[i] <= 32'd0;
            mem_rd <= 32'd0;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wd;
                mem_rd        <= mem_wd;
            end else begin
                mem_rd <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [AW-1:0] da, input logic [31:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wd = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wd = dd;
    endtask

    typedef struct {
        logic cr, cw; logic [AW-1:0] ca; logic [31:0] cd;
        logic dr, dw; logic [AW-1:0] da; logic [31:0] dd;
        logic xcg, xdg, xst, xcak, xdak;
        logic [31:0] xcrd, xdrd;
    } vec_t;

    vec_t vecs [11];

    // Transaction-level model state for the random phase.
    logic [31:0] shadow [0:(1<<AW)-1];
    int          denied;
    int          prev_port;   // 0 none, 1 cpu, 2 dbg
    logic        prev_read;
    logic [31:0] prev_data;

    initial begin
        //                 cr   cw  ca    cd             dr   dw  da    dd              cg dg st cak dak crd            drd
        vecs[0]  = '{1'b1,1'b1,6'd5,32'hDEADBEEF, 1'b0,1'b0,6'd0,32'h0,        1,0,0,0,0, 32'h0,        32'h0};
        vecs[1]  = '{1'b1,1'b0,6'd5,32'h0,        1'b0,1'b0,6'd0,32'h0,        1,0,0,1,0, 32'h0,        32'h0};
        vecs[2]  = '{1'b0,1'b0,6'd0,32'h0,        1'b0,1'b0,6'd0,32'h0,        0,0,0,1,0, 32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0,1'b0,6'd0,32'h0,        1'b1,1'b1,6'd9,32'h12345678, 0,1,0,0,0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0,1'b0,6'd0,32'h0,        1'b1,1'b0,6'd9,32'h0,        0,1,0,0,1, 32'h0,        32'h0};
        vecs[5]  = '{1'b0,1'b0,6'd0,32'h0,        1'b0,1'b0,6'd0,32'h0,        0,0,0,0,1, 32'h0,        32'h12345678};
        vecs[6]  = '{1'b1,1'b1,6'd1,32'h11111111, 1'b1,1'b1,6'd2,32'h22222222, 1,0,0,0,0, 32'h0,        32'h0};
        vecs[7]  = '{1'b0,1'b0,6'd0,32'h0,        1'b1,1'b1,6'd2,32'h22222222, 0,1,0,1,0, 32'h0,        32'h0};
        vecs[8]  = '{1'b1,1'b0,6'd1,32'h0,        1'b1,1'b0,6'd2,32'h0,        1,0,0,0,1, 32'h0,        32'h0};
        vecs[9]  = '{1'b0,1'b0,6'd0,32'h0,        1'b1,1'b0,6'd2,32'h0,        0,1,0,1,0, 32'h11111111, 32'h0};
        vecs[10] = '{1'b0,1'b0,6'd0,32'h0,        1'b0,1'b0,6'd0,32'h0,        0,0,0,0,1, 32'h0,        32'h22222222};

        for (int i = 0; i < (1<<AW); i++) shadow[i] = 32'd0;

        // Reset held 3 cycles with both ports requesting.
        ram_clr = 1'b1;
        rst     = 1'b1;
        drive(1'b1, 1'b0, 6'd3, 32'h0, 1'b1, 1'b0, 6'd4, 32'h0);
        @(posedge clk); #1 ram_clr = 1'b0;
        @(negedge clk);
        chk("rst_cpu_gnt_live", {31'd0, cpu_gnt}, 32'd1);
        chk("rst_dbg_gnt_live", {31'd0, dbg_gnt}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
        @(negedge clk);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_cpu_rd", cpu_rd, 32'd0);
        chk("rst_dbg_rd", dbg_rd, 32'd0);
        chk("rst_mem_en_idle", {31'd0, mem_en}, 32'd0);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            logic [AW-1:0] xa;
            logic [31:0]   xw;
            @(posedge clk); #1;
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
            xa = vecs[i].xcg ? vecs[i].ca : (vecs[i].xdg ? vecs[i].da : '0);
            xw = vecs[i].xcg ? vecs[i].cd : (vecs[i].xdg ? vecs[i].dd : '0);
            @(negedge clk);
            chk($sformatf("v%0d_cpu_gnt", i), {31'd0, cpu_gnt}, {31'd0, vecs[i].xcg});
            chk($sformatf("v%0d_dbg_gnt", i), {31'd0, dbg_gnt}, {31'd0, vecs[i].xdg});
            chk($sformatf("v%0d_cpu_stall", i), {31'd0, cpu_stall}, {31'd0, vecs[i].xst});
            chk($sformatf("v%0d_cpu_ack", i), {31'd0, cpu_ack}, {31'd0, vecs[i].xcak});
            chk($sformatf("v%0d_dbg_ack", i), {31'd0, dbg_ack}, {31'd0, vecs[i].xdak});
            chk($sformatf("v%0d_cpu_rd", i), cpu_rd, vecs[i].xcrd);
            chk($sformatf("v%0d_dbg_rd", i), dbg_rd, vecs[i].xdrd);
            chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].xcg | vecs[i].xdg});
            chk($sformatf("v%0d_mem_addr", i), {26'd0, mem_addr}, {26'd0, xa});
            chk($sformatf("v%0d_mem_wd", i), mem_wd, xw);
        end

        // Starvation: both ports hold read requests for 20 cycles after a fresh reset.
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 6'd5, 32'h0, 1'b1, 1'b0, 6'd9, 32'h0);
        for (int i = 0; i < 20; i++) begin
            logic xdg;
            xdg = ((i % 5) == 4);
            @(negedge clk);
            chk($sformatf("starve%0d_cpu_gnt", i), {31'd0, cpu_gnt}, {31'd0, ~xdg});
            chk($sformatf("starve%0d_dbg_gnt", i), {31'd0, dbg_gnt}, {31'd0, xdg});
            chk($sformatf("starve%0d_cpu_stall", i), {31'd0, cpu_stall}, {31'd0, xdg});
            if (i > 0) begin
                logic pdg;
                pdg = (((i - 1) % 5) == 4);
                chk($sformatf("starve%0d_cpu_rd", i), cpu_rd, pdg ? 32'h0 : 32'hDEADBEEF);
                chk($sformatf("starve%0d_dbg_rd", i), dbg_rd, pdg ? 32'h12345678 : 32'h0);
            end
            @(posedge clk); #1;
        end
`ifdef SM_DMEM_ARB_STATS_EN
        chk("stat_dbg_grants", {16'd0, stat_dbg_grants}, 32'd4);
        chk("stat_stalls", {16'd0, stat_stalls}, 32'd4);
`endif
        drive(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);

        // Random traffic on the upper half of the RAM, checked against the model.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        denied    = 0;
        prev_port = 0;
        prev_read = 1'b0;
        prev_data = 32'h0;
        for (int n = 0; n < 500; n++) begin
            logic          cr, cw, dr, dw, xcg, xdg;
            logic [AW-1:0] ca, da;
            logic [31:0]   cd, dd;
            cr = ($urandom_range(0, 3) != 0);
            cw = $urandom_range(0, 1) == 1;
            ca = AW'($urandom_range(32, 63));
            cd = $urandom;
            dr = $urandom_range(0, 1) == 1;
            dw = $urandom_range(0, 1) == 1;
            da = AW'($urandom_range(32, 63));
            dd = $urandom;
            drive(cr, cw, ca, cd, dr, dw, da, dd);
            xdg = dr && ((denied >= MAX_WAIT) || !cr);
            xcg = cr && !xdg;
            @(negedge clk);
            chk("rnd_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, xcg});
            chk("rnd_dbg_gnt", {31'd0, dbg_gnt}, {31'd0, xdg});
            chk("rnd_cpu_stall", {31'd0, cpu_stall}, {31'd0, cr && !xcg});
            chk("rnd_cpu_ack", {31'd0, cpu_ack}, {31'd0, prev_port == 1});
            chk("rnd_dbg_ack", {31'd0, dbg_ack}, {31'd0, prev_port == 2});
            chk("rnd_cpu_rd", cpu_rd, (prev_port == 1 && prev_read) ? prev_data : 32'h0);
            chk("rnd_dbg_rd", dbg_rd, (prev_port == 2 && prev_read) ? prev_data : 32'h0);
            chk("rnd_mem_en", {31'd0, mem_en}, {31'd0, xcg || xdg});
            chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, (xcg && cw) || (xdg && dw)});
            chk("rnd_mem_addr", {26'd0, mem_addr}, {26'd0, xcg ? ca : (xdg ? da : 6'd0)});
            chk("rnd_mem_wd", mem_wd, xcg ? cd : (xdg ? dd : 32'h0));
            prev_port = xcg ? 1 : (xdg ? 2 : 0);
            prev_read = 1'b0;
            prev_data = 32'h0;
            if (xcg) begin
                prev_read = !cw;
                if (cw) shadow[ca] = cd; else prev_data = shadow[ca];
            end else if (xdg) begin
                prev_read = !dw;
                if (dw) shadow[da] = dd; else prev_data = shadow[da];
            end
            denied = (dr && !xdg) ? denied + 1 : 0;
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
